// File: rtl/switch_pkg.sv
// Shared definitions for the board switch/LED paths.
//   SW_WIDTH       : number of slide switches / LEDs
//   byte_swap16    : exchanges the two bytes of a 16-bit word; the board
//                    wires both the LED and the switch bytes swapped
//   report_state_t : states of the switch report handshake
package switch_pkg;

    localparam int SW_WIDTH = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } report_state_t;

    function automatic logic [SW_WIDTH-1:0] byte_swap16(input logic [SW_WIDTH-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser, disagreement counter and stable bit.
// The stable bit flips only after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; any earlier return to agreement
// clears the counter.
// Ports:
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   raw_i    : asynchronous switch pin
//   stable_o : debounced level
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter stops at CNT_LAST: reaching it with the bit still differing
    // commits the flip and clears, so it can never wrap.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/switch_capture.sv
// Switch input path: debounces the 16 slide switches, restores logical bit
// order and reports each settled word to the core over valid/ready.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   sw_raw      : switch pins (bytes swapped by board wiring), asynchronous
//   sw_level    : current debounced word, logical order
//   value_data  : reported word, held while value_valid is high
//   value_valid : report pending
//   value_ready : consumer accepts on value_valid & value_ready
module switch_capture
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [SW_WIDTH-1:0] sw_level,
    output logic [SW_WIDTH-1:0] value_data,
    output logic                value_valid,
    input  logic                value_ready
);

    logic [SW_WIDTH-1:0] stable;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i   (clk),
            .rst_i   (rst),
            .raw_i   (sw_raw[i]),
            .stable_o(stable[i])
        );
    end

    assign sw_level = byte_swap16(stable);

    report_state_t       state_q, state_d;
    logic [SW_WIDTH-1:0] data_q, data_d;
    logic [SW_WIDTH-1:0] last_q, last_d;
    logic                valid_q, valid_d;

    // Changes seen during HOLD are not queued; IDLE re-compares against the
    // live level, so only the latest settled word gets reported.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (sw_level != last_q) begin
                    data_d  = sw_level;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && value_ready) begin
                    last_d  = data_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign value_data  = data_q;
    assign value_valid = valid_q;

endmodule

// File: tb/tb_switch_capture.sv
// Self-checking bench for switch_capture with DEBOUNCE_CYCLES=4.
// A behavioural model (raw sample history, run lengths of disagreement,
// arithmetic byte swap, single pending-report slot) is compared against the
// DUT on every cycle; directed scenarios add literal expectations.
module tb_switch_capture;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic [15:0] sw_raw;
    logic [15:0] sw_level;
    logic [15:0] value_data;
    logic        value_valid;
    logic        value_ready;

    switch_capture #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_level   (sw_level),
        .value_data (value_data),
        .value_valid(value_valid),
        .value_ready(value_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] swap(input logic [15:0] w);
        return ((w & 16'h00FF) << 8) | (w >> 8);
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0] m_h1, m_h2;      // raw as sampled one and two edges ago
    logic [15:0] m_stable;
    logic [15:0] m_data, m_last, m_lvl;
    bit          m_valid;
    int          run[16];         // consecutive edges the sample disagreed

    always @(posedge clk) begin
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_stable = '0;
            m_data = '0; m_last = '0; m_valid = 0;
            for (int i = 0; i < 16; i++) run[i] = 0;
        end else begin
            m_lvl = swap(m_stable);
            if (m_valid) begin
                if (value_ready) begin
                    m_last  = m_data;
                    m_valid = 0;
                end
            end else if (m_lvl != m_last) begin
                m_data  = m_lvl;
                m_valid = 1;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_h2[i] != m_stable[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        m_stable[i] = m_h2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = sw_raw;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("sw_level", 32'(sw_level), 32'(swap(m_stable)));
            chk("value_valid", 32'(value_valid), 32'(m_valid));
            chk("value_data", 32'(value_data), 32'(m_data));
        end
    end

    // handshake log taken from the pins
    int          n_acc = 0;
    logic [15:0] last_acc = '0;
    always @(posedge clk) begin
        if (!rst && value_valid === 1'b1 && value_ready === 1'b1) begin
            n_acc++;
            last_acc = value_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    // Returns the index (0 = first edge) of the first edge after which
    // value_valid is high, or -1 if the bound expires.
    task automatic wait_valid(input int bound, output int first);
        first = -1;
        for (int k = 0; k < bound; k++) begin
            step(1);
            if (value_valid === 1'b1) begin
                first = k;
                break;
            end
        end
    endtask

    int first;
    int n0;
    bit saw;
    int hold;

    initial begin
        rst = 1'b1;
        sw_raw = '0;
        value_ready = 1'b0;
        step(1);
        chk_en = 1;
        step(2);
        rst = 1'b0;

        // reset with switches off
        chk("rst value_valid", 32'(value_valid), 32'd0);
        chk("rst value_data", 32'(value_data), 32'd0);
        saw = 0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (value_valid !== 1'b0) saw = 1;
        end
        chk("idle no report", 32'(saw), 32'd0);
        chk("idle sw_level", 32'(sw_level), 32'h0000);

        // single change with byte swap
        value_ready = 1'b1;
        sw_raw = 16'h00A5;
        n0 = n_acc;
        wait_valid(30, first);
        chk("swap valid edge", 32'(first), 32'd6);
        chk("swap data", 32'(value_data), 32'h0000A500);
        step(20);
        chk("swap reports", 32'(n_acc - n0), 32'd1);
        chk("swap cleared", 32'(value_valid), 32'd0);

        sw_raw = '0;
        do_reset(2);
        step(5);

        // glitch rejection
        n0 = n_acc;
        sw_raw = 16'h0001;
        step(3);
        sw_raw = 16'h0000;
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (value_valid !== 1'b0) saw = 1;
        end
        chk("glitch no report", 32'(saw), 32'd0);
        chk("glitch sw_level", 32'(sw_level), 32'h0000);

        // bounce
        n0 = n_acc;
        for (int k = 0; k < 10; k++) begin
            sw_raw[3] = ~sw_raw[3];
            step(2);
        end
        sw_raw[3] = 1'b1;
        step(25);
        chk("bounce reports", 32'(n_acc - n0), 32'd1);
        chk("bounce data", 32'(last_acc), 32'h00000800);

        sw_raw = '0;
        do_reset(2);
        step(5);

        // backpressure and coalescing
        value_ready = 1'b0;
        sw_raw = 16'h0001;
        wait_valid(30, first);
        chk("bp report1 seen", 32'(first >= 0), 32'd1);
        chk("bp report1 data", 32'(value_data), 32'h00000100);
        sw_raw = 16'h0003;
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (value_data !== 16'h0100 || value_valid !== 1'b1) saw = 1;
        end
        chk("bp held", 32'(saw), 32'd0);
        value_ready = 1'b1;
        step(1);
        value_ready = 1'b0;
        chk("bp after accept", 32'(value_valid), 32'd0);
        step(1);
        chk("bp report2 valid", 32'(value_valid), 32'd1);
        chk("bp report2 data", 32'(value_data), 32'h00000300);
        value_ready = 1'b1;
        step(3);

        sw_raw = '0;
        do_reset(2);
        step(5);

        // reset mid-HOLD
        value_ready = 1'b0;
        sw_raw = 16'h00A5;
        wait_valid(30, first);
        chk("mid report data", 32'(value_data), 32'h0000A500);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid rst valid", 32'(value_valid), 32'd0);
        chk("mid rst data", 32'(value_data), 32'h0000);
        chk("mid rst level", 32'(sw_level), 32'h0000);
        wait_valid(30, first);
        chk("mid re-report edge", 32'(first), 32'd6);
        chk("mid re-report data", 32'(value_data), 32'h0000A500);
        value_ready = 1'b1;
        step(3);

        // randomized traffic against the model
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0)
                    sw_raw = 16'($urandom);
                else
                    sw_raw[$urandom_range(0, 15)] = ~sw_raw[$urandom_range(0, 15)];
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            value_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0;
        value_ready = 1'b1;
        step(40);
        chk("final level", 32'(sw_level), 32'(swap(sw_raw)));
        chk("final idle", 32'(value_valid), 32'd0);
        chk("model last_sent", 32'(m_last), 32'(swap(sw_raw)));

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
